// File: rtl/dcache_axi_pkg.sv
// dcache_axi_pkg: shared definitions for the L1 data cache AXI4 master bridge.
//   state_t        : bridge FSM states
//   BURST_INCR, SIZE_WORD, RESP_OKAY : AXI4 field encodings used by the bridge
//   TYPE_*         : cache access-type codes carried on type_i
//   BURST_LEN_LINE : AXLEN of a cache-line fill (4 beats)
package dcache_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_AR    = 3'd1,
        ST_R     = 3'd2,
        ST_WR    = 3'd3,
        ST_B     = 3'd4,
        ST_DRAIN = 3'd5
    } state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_WORD  = 3'b010;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    localparam logic [2:0] TYPE_BYTE    = 3'b000;
    localparam logic [2:0] TYPE_HWORD   = 3'b001;
    localparam logic [2:0] TYPE_WORD    = 3'b010;
    localparam logic [2:0] TYPE_BYTE_U  = 3'b100;
    localparam logic [2:0] TYPE_HWORD_U = 3'b101;

    localparam logic [3:0] BURST_LEN_LINE = 4'd3;

endpackage

// File: rtl/dcache_axi_wstrb.sv
// dcache_axi_wstrb: byte-lane strobe generation for single-beat writes.
//   type_i [2:0] : cache access type
//   addr_i [1:0] : low address bits selecting the lane(s)
//   wstrb  [3:0] : AXI write strobe
// Signed and unsigned variants of a size use identical lanes.
module dcache_axi_wstrb
    import dcache_axi_pkg::*;
(
    input  logic [2:0] type_i,
    input  logic [1:0] addr_i,
    output logic [3:0] wstrb
);

    always_comb begin
        wstrb = 4'b1111;
        case (type_i)
            TYPE_BYTE, TYPE_BYTE_U:   wstrb = 4'b0001 << addr_i;
            TYPE_HWORD, TYPE_HWORD_U: wstrb = addr_i[1] ? 4'b1100 : 4'b0011;
            TYPE_WORD:                wstrb = 4'b1111;
            default:                  wstrb = 4'b1111;
        endcase
    end

endmodule

// File: rtl/dcache_axi_master.sv
// dcache_axi_master: bridge from the L1 data cache request/wait interface to
// an AXI4 master. Cacheable reads become 4-beat INCR bursts, uncacheable reads
// single beats, writes single beats with byte strobes. Every delivered read
// beat and every write completion is signalled by a one-cycle low on wait_o.
// Ports:
//   clk, rst (async, active-high)
//   cache side : rreq_i, wreq_i, addr_i, wdata_i, type_i, arlenone_i -> rdata_o, wait_o
//   AXI AR/R, AW/W/B master channels
//   dbg_state  : current FSM state, for observation only
// Optional build macro DCACHE_AXI_RESP_ERR_EN adds err_o / err_addr_o, a sticky
// record of the first non-OKAY read or write response.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1; a raised valid and its payload hold steady until that transfer.
module dcache_axi_master
    import dcache_axi_pkg::*;
#(
    parameter int              ID_W  = 4,
    parameter logic [ID_W-1:0] RD_ID = '0,
    parameter logic [ID_W-1:0] WR_ID = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rreq_i,
    input  logic            wreq_i,
    input  logic [31:0]     addr_i,
    input  logic [31:0]     wdata_i,
    input  logic [2:0]      type_i,
    input  logic            arlenone_i,
    output logic [31:0]     rdata_o,
    output logic            wait_o,
    output logic [ID_W-1:0] arid,
    output logic [31:0]     araddr,
    output logic [3:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    output logic            arvalid,
    input  logic            arready,
    input  logic [ID_W-1:0] rid,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic            rvalid,
    output logic            rready,
    output logic [ID_W-1:0] awid,
    output logic [31:0]     awaddr,
    output logic [3:0]      awlen,
    output logic [2:0]      awsize,
    output logic [1:0]      awburst,
    output logic            awvalid,
    input  logic            awready,
    output logic [31:0]     wdata,
    output logic [3:0]      wstrb,
    output logic            wlast,
    output logic            wvalid,
    input  logic            wready,
    input  logic [ID_W-1:0] bid,
    input  logic [1:0]      bresp,
    input  logic            bvalid,
    output logic            bready,
`ifdef DCACHE_AXI_RESP_ERR_EN
    output logic            err_o,
    output logic [31:0]     err_addr_o,
`endif
    output state_t          dbg_state
);

    state_t      state_q, state_d;
    logic [31:0] addr_q, wdata_q;
    logic [2:0]  type_q;
    logic        arlenone_q;
    logic        aw_done_q, w_done_q;
    logic        r_hs, b_hs, aw_fin, w_fin, launch;

    assign launch = (state_q == ST_IDLE) && (wreq_i || rreq_i);

    // AR/AW/W payloads come straight from the request registers, so they are
    // stable for as long as the corresponding valid is held.
    assign arid    = RD_ID;
    assign araddr  = addr_q;
    assign arlen   = arlenone_q ? 4'd0 : BURST_LEN_LINE;
    assign arsize  = SIZE_WORD;
    assign arburst = BURST_INCR;
    assign arvalid = (state_q == ST_AR);
    assign rready  = (state_q == ST_R);

    assign awid    = WR_ID;
    assign awaddr  = addr_q;
    assign awlen   = 4'd0;
    assign awsize  = SIZE_WORD;
    assign awburst = BURST_INCR;
    assign awvalid = (state_q == ST_WR) && !aw_done_q;
    assign wdata   = wdata_q;
    assign wlast   = 1'b1;
    assign wvalid  = (state_q == ST_WR) && !w_done_q;
    assign bready  = (state_q == ST_B);

    assign r_hs = rvalid && rready;
    assign b_hs = bvalid && bready;

    // A channel counts as finished if it completed earlier or completes now,
    // so AW and W may finish in either order or together.
    assign aw_fin = aw_done_q || (awvalid && awready);
    assign w_fin  = w_done_q  || (wvalid && wready);

    assign dbg_state = state_q;

    dcache_axi_wstrb u_wstrb (
        .type_i (type_q),
        .addr_i (addr_q[1:0]),
        .wstrb  (wstrb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (wreq_i)      state_d = ST_WR;
                else if (rreq_i) state_d = ST_AR;
            end
            ST_AR:    if (arready)        state_d = ST_R;
            ST_R:     if (rvalid && rlast) state_d = ST_DRAIN;
            ST_WR:    if (aw_fin && w_fin) state_d = ST_B;
            ST_B:     if (bvalid)         state_d = ST_DRAIN;
            // The cache keeps its request up until it sees the final pulse;
            // wait for it to drop so the same request is not issued twice.
            ST_DRAIN: if (!rreq_i && !wreq_i) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            type_q     <= '0;
            arlenone_q <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            rdata_o    <= '0;
            wait_o     <= 1'b1;
        end else begin
            wait_o <= 1'b1;
            if (launch) begin
                addr_q     <= addr_i;
                wdata_q    <= wdata_i;
                type_q     <= type_i;
                arlenone_q <= arlenone_i;
                aw_done_q  <= 1'b0;
                w_done_q   <= 1'b0;
            end
            if (awvalid && awready) aw_done_q <= 1'b1;
            if (wvalid && wready)   w_done_q  <= 1'b1;
            if (r_hs) begin
                rdata_o <= rdata;
                wait_o  <= 1'b0;
            end
            if (b_hs) wait_o <= 1'b0;
        end
    end

`ifdef DCACHE_AXI_RESP_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_o      <= 1'b0;
            err_addr_o <= '0;
        end else if (!err_o && ((r_hs && rresp != RESP_OKAY) ||
                                (b_hs && bresp != RESP_OKAY))) begin
            err_o      <= 1'b1;
            err_addr_o <= addr_q;
        end
    end

    logic unused_ids;
    assign unused_ids = ^{rid, bid};
`else
    logic unused_resp;
    assign unused_resp = ^{rid, bid, rresp, bresp};
`endif

endmodule

// File: tb/tb_dcache_axi_master.sv
// tb_dcache_axi_master: directed bench for dcache_axi_master. Driver tasks act
// as cache and AXI slave; expected wait_o pulse data is queued as each beat or
// write response is issued and a monitor pops it on every wait_o low cycle.
module tb_dcache_axi_master;
  import dcache_axi_pkg::*;

  localparam int ID_W = 4;

  logic clk = 1'b0;
  logic rst;
  logic rreq_i, wreq_i, arlenone_i;
  logic [31:0] addr_i, wdata_i;
  logic [2:0] type_i;
  logic [31:0] rdata_o;
  logic wait_o;
  logic [ID_W-1:0] arid, rid, awid, bid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [3:0] arlen, awlen, wstrb;
  logic [2:0] arsize, awsize;
  logic [1:0] arburst, awburst, rresp, bresp;
  logic arvalid, arready, rlast, rvalid, rready;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
`ifdef DCACHE_AXI_RESP_ERR_EN
  logic err_o;
  logic [31:0] err_addr_o;
`endif
  state_t dbg_state;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_rdata = '0;

  dcache_axi_master #(.ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .rreq_i(rreq_i), .wreq_i(wreq_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .type_i(type_i), .arlenone_i(arlenone_i), .rdata_o(rdata_o), .wait_o(wait_o),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
`ifdef DCACHE_AXI_RESP_ERR_EN
    .err_o(err_o), .err_addr_o(err_addr_o),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst === 1'b0 && wait_o === 1'b0) begin
      if (exp_q.size() == 0) check("unexpected_wait_pulse", 32'd1, 32'd0);
      else check("pulse_rdata", rdata_o, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic do_read(input logic [31:0] addr, input logic one,
                         input logic [31:0] base, input int send);
    int t;
    int nb;
    nb = one ? 1 : 4;
    @(posedge clk); #1;
    rreq_i = 1'b1; addr_i = addr; arlenone_i = one; type_i = TYPE_WORD;
    @(negedge clk);
    t = 0;
    while (arvalid !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    check("arvalid_seen", {31'd0, arvalid}, 32'd1);
    check("araddr", araddr, addr);
    check("arlen", {28'd0, arlen}, one ? 32'd0 : 32'd3);
    check("arsize", {29'd0, arsize}, 32'd2);
    check("arburst", {30'd0, arburst}, 32'd1);
    check("arid", {28'd0, arid}, 32'd0);
    arready = 1'b1;
    @(posedge clk); #1;
    arready = 1'b0;
    for (int i = 0; i < send; i++) begin
      rvalid = 1'b1; rdata = base + i; rlast = (i == nb - 1); rresp = 2'b00; rid = '0;
      exp_q.push_back(base + i);
      @(negedge clk);
      t = 0;
      while (rready !== 1'b1 && t < 20) begin @(negedge clk); t++; end
      check("rready", {31'd0, rready}, 32'd1);
      check("wait_before_beat", {31'd0, wait_o}, 32'd1);
      @(posedge clk); #1;
      rvalid = 1'b0; rlast = 1'b0;
      exp_rdata = base + i;
      @(negedge clk);
      check("beat_latency", {31'd0, wait_o}, 32'd0);
      @(posedge clk); #1;
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [2:0] typ,
                          input logic [31:0] data, input logic [3:0] strb,
                          input int w_dly, input int aw_dly,
                          input logic [1:0] resp, input logic also_read);
    int t;
    logic aw_ok, w_ok;
    @(posedge clk); #1;
    wreq_i = 1'b1; rreq_i = also_read; addr_i = addr; type_i = typ;
    wdata_i = data; arlenone_i = 1'b0;
    @(negedge clk);
    t = 0;
    while (awvalid !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    check("awvalid_seen", {31'd0, awvalid}, 32'd1);
    check("wvalid_seen", {31'd0, wvalid}, 32'd1);
    check("awaddr", awaddr, addr);
    check("awlen", {28'd0, awlen}, 32'd0);
    check("awsize", {29'd0, awsize}, 32'd2);
    check("awburst", {30'd0, awburst}, 32'd1);
    check("awid", {28'd0, awid}, 32'd0);
    check("wdata", wdata, data);
    check("wstrb", {28'd0, wstrb}, {28'd0, strb});
    check("wlast", {31'd0, wlast}, 32'd1);
    aw_ok = 1'b0; w_ok = 1'b0; t = 0;
    while (!(aw_ok && w_ok) && t < 50) begin
      check("no_arvalid_in_write", {31'd0, arvalid}, 32'd0);
      if (aw_ok) check("awvalid_dropped", {31'd0, awvalid}, 32'd0);
      else begin
        check("aw_stall_valid", {31'd0, awvalid}, 32'd1);
        check("aw_stall_addr", awaddr, addr);
      end
      if (w_ok) check("wvalid_dropped", {31'd0, wvalid}, 32'd0);
      awready = (t >= aw_dly) && !aw_ok;
      wready  = (t >= w_dly) && !w_ok;
      if (awvalid && awready) aw_ok = 1'b1;
      if (wvalid && wready) w_ok = 1'b1;
      @(posedge clk); #1;
      awready = 1'b0; wready = 1'b0;
      @(negedge clk);
      t++;
    end
    check("aw_w_done", {31'd0, aw_ok && w_ok}, 32'd1);
    t = 0;
    while (bready !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    check("bready", {31'd0, bready}, 32'd1);
    check("wait_before_b", {31'd0, wait_o}, 32'd1);
    bvalid = 1'b1; bresp = resp; bid = '0;
    exp_q.push_back(exp_rdata);
    @(posedge clk); #1;
    bvalid = 1'b0; bresp = 2'b00;
    @(negedge clk);
    check("b_latency", {31'd0, wait_o}, 32'd0);
    @(posedge clk); #1;
    wreq_i = 1'b0; rreq_i = 1'b0;
  endtask

  task automatic expect_idle_no_ar(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check("no_relaunch_ar", {31'd0, arvalid}, 32'd0);
    end
  endtask

  // stimulus
  initial begin
    rst = 1'b1;
    rreq_i = 0; wreq_i = 0; arlenone_i = 0; addr_i = '0; wdata_i = '0; type_i = '0;
    arready = 0; rid = '0; rdata = '0; rresp = '0; rlast = 0; rvalid = 0;
    awready = 0; wready = 0; bid = '0; bresp = '0; bvalid = 0;
    @(negedge clk);
    check("rst_wait", {31'd0, wait_o}, 32'd1);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_valids", {28'd0, arvalid, rready, awvalid, wvalid}, 32'd0);
    check("rst_bready", {31'd0, bready}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
`ifdef DCACHE_AXI_RESP_ERR_EN
    check("rst_err", {31'd0, err_o}, 32'd0);
    check("rst_err_addr", err_addr_o, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // cacheable line fill, then hold rreq for 3 cycles
    do_read(32'h0000_1230, 1'b0, 32'h0000_00A0, 4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("held_no_arvalid", {31'd0, arvalid}, 32'd0);
      check("held_drain", {29'd0, dbg_state}, {29'd0, ST_DRAIN});
    end
    @(posedge clk); #1;
    rreq_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("drain_to_idle", {29'd0, dbg_state}, {29'd0, ST_IDLE});

    // uncacheable single-beat read
    do_read(32'h1000_0004, 1'b1, 32'hDEAD_BEEF, 1);
    @(posedge clk); #1;
    rreq_i = 1'b0;

    // byte write: W accepted 2 cycles before AW
    do_write(32'h0000_2003, TYPE_BYTE, 32'h7700_0000, 4'b1000, 0, 2, 2'b00, 1'b0);
    // word write: AW before W
    do_write(32'h0000_5000, TYPE_WORD, 32'h1122_3344, 4'b1111, 3, 0, 2'b00, 1'b0);
    // unsigned halfword low lane, AW and W in the same cycle
    do_write(32'h0000_5008, TYPE_HWORD_U, 32'h0000_BEEF, 4'b0011, 0, 0, 2'b00, 1'b0);
    // unsigned byte lane 1
    do_write(32'h0000_5011, TYPE_BYTE_U, 32'h0000_5500, 4'b0010, 1, 1, 2'b00, 1'b0);
    // collision with a read, AW stalled 5 cycles: read must not follow
    do_write(32'h0000_3002, TYPE_HWORD, 32'h1234_0000, 4'b1100, 0, 5, 2'b00, 1'b1);
    expect_idle_no_ar(4);

`ifdef DCACHE_AXI_RESP_ERR_EN
    check("no_err_yet", {31'd0, err_o}, 32'd0);
    do_write(32'h4000_0010, TYPE_WORD, 32'hCAFE_0001, 4'b1111, 0, 0, 2'b10, 1'b0);
    @(negedge clk);
    check("err_set", {31'd0, err_o}, 32'd1);
    check("err_addr", err_addr_o, 32'h4000_0010);
    do_write(32'h4000_0020, TYPE_WORD, 32'hCAFE_0002, 4'b1111, 0, 0, 2'b11, 1'b0);
    @(negedge clk);
    check("err_first_kept", err_addr_o, 32'h4000_0010);
`endif

    // reset in the middle of a burst, after two beats
    do_read(32'h0000_6000, 1'b0, 32'h0000_0055, 2);
    @(negedge clk);
    check("mid_burst_state", {29'd0, dbg_state}, {29'd0, ST_R});
    rst = 1'b1;
    #1;
    exp_rdata = '0;
    check("mid_rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    check("mid_rst_rready", {31'd0, rready}, 32'd0);
    check("mid_rst_wait", {31'd0, wait_o}, 32'd1);
    check("mid_rst_rdata", rdata_o, 32'd0);
`ifdef DCACHE_AXI_RESP_ERR_EN
    check("mid_rst_err", {31'd0, err_o}, 32'd0);
`endif
    rreq_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // recovery after reset
    do_read(32'h0000_7000, 1'b1, 32'h0BAD_F00D, 1);
    @(posedge clk); #1;
    rreq_i = 1'b0;
    repeat (4) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
